// File: rtl/mem_pkg.sv
// Shared memory-access encodings, used by the data memory and the control unit.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } memSize_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/load_formatter.sv
// Load path: picks the addressed lane(s) out of a memory word and sign/zero-extends them.
module load_formatter
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [1:0]            byteOff,
    input  memSize_e              size,
    input  logic                  isUnsigned,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;

    // Move the addressed lane down to bit 0; little-endian, so lane k sits at bit 8k.
    assign shifted = word >> {byteOff, 3'b000};

    always_comb begin
        data = '0;
        if (enable) begin
            case (size)
                MEM_BYTE: data = {{(DATA_WIDTH-8){~isUnsigned & shifted[7]}}, shifted[7:0]};
                MEM_HALF: data = {{(DATA_WIDTH-16){~isUnsigned & shifted[15]}}, shifted[15:0]};
                MEM_WORD: data = word;
                default:  data = '0;
            endcase
        end
    end

endmodule

// File: rtl/data_memory.sv
// Byte-addressable data memory with combinational loads, byte-lane stores and a sticky
// misaligned-access fault register.
module data_memory
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [1:0]            memSize,
    input  logic                  memUnsigned,
    input  logic                  faultClear,
    output logic [DATA_WIDTH-1:0] readData,
    output logic                  misaligned,
    output logic                  faultFlag,
    output logic [31:0]           faultAddr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    memSize_e              sizeE;
    logic [IDX_W-1:0]      wordIdx;
    logic [1:0]            byteOff;
    logic [WORD_BYTES-1:0] byteEn;
    logic [DATA_WIDTH-1:0] wrLanes;
    logic [DATA_WIDTH-1:0] rdWord;
    logic                  aligned;
    logic                  unusedAddrBits;

    assign sizeE   = memSize_e'(memSize);
    assign wordIdx = address[IDX_W+1:2];
    assign byteOff = address[1:0];
    assign rdWord  = mem[wordIdx];

    // Upper address bits are deliberately dropped so out-of-range addresses wrap.
    assign unusedAddrBits = ^address[31:IDX_W+2];

    // Store data is replicated across lanes so byteEn alone decides what lands.
    always_comb begin
        aligned = 1'b0;
        byteEn  = '0;
        wrLanes = '0;
        case (sizeE)
            MEM_BYTE: begin
                aligned = 1'b1;
                byteEn  = 4'b0001 << byteOff;
                wrLanes = {4{writeData[7:0]}};
            end
            MEM_HALF: begin
                aligned = ~byteOff[0];
                byteEn  = byteOff[1] ? 4'b1100 : 4'b0011;
                wrLanes = {2{writeData[15:0]}};
            end
            MEM_WORD: begin
                aligned = (byteOff == 2'b00);
                byteEn  = 4'b1111;
                wrLanes = writeData;
            end
            default: ;
        endcase
    end

    assign misaligned = (memRead | memWrite) & ~aligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (memWrite && !misaligned) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (byteEn[b]) begin
                    mem[wordIdx][8*b +: 8] <= wrLanes[8*b +: 8];
                end
            end
        end
    end

    // A fresh fault beats a clear on the same edge; otherwise the first fault is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            faultFlag <= 1'b0;
            faultAddr <= '0;
        end else if (misaligned && (!faultFlag || faultClear)) begin
            faultFlag <= 1'b1;
            faultAddr <= address;
        end else if (faultClear) begin
            faultFlag <= 1'b0;
        end
    end

    load_formatter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_loadFormatter (
        .word      (rdWord),
        .byteOff   (byteOff),
        .size      (sizeE),
        .isUnsigned(memUnsigned),
        .enable    (memRead & ~misaligned),
        .data      (readData)
    );

endmodule

// File: tb/tb_data_memory.sv
// Directed and randomized checks of data_memory against a byte-array reference model.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  memSize;
    logic        memUnsigned;
    logic        faultClear;
    logic [31:0] readData;
    logic        misaligned;
    logic        faultFlag;
    logic [31:0] faultAddr;

    data_memory #(
        .DATA_WIDTH (32),
        .DEPTH_WORDS(256)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .writeData  (writeData),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .memSize    (memSize),
        .memUnsigned(memUnsigned),
        .faultClear (faultClear),
        .readData   (readData),
        .misaligned (misaligned),
        .faultFlag  (faultFlag),
        .faultAddr  (faultAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    // Reference state: 1 KiB of bytes plus the sticky fault pair.
    logic [7:0]  refMem [1024];
    logic        refFlag;
    logic [31:0] refAddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic refIsMis(input logic [31:0] a, input logic [1:0] sz);
        case (sz)
            2'd0:    return 1'b0;
            2'd1:    return (a % 2) != 0;
            2'd2:    return (a % 4) != 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [1:0] sz,
                                            input logic uns);
        int          n;
        int          base;
        logic [31:0] v;
        n    = 1 << sz;
        base = int'(a % 1024);
        v    = 0;
        for (int i = 0; i < n; i++) v = v + (32'(refMem[base + i]) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v - (32'd1 << (8 * n));
        return v;
    endfunction

    // One clock of stimulus: checks the combinational outputs before the edge and the
    // fault registers after it, advancing the model in between.
    task automatic cycle(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns,
                         input logic clr, input logic r, output logic [31:0] obs);
        logic        expMis;
        logic [31:0] expRd;
        int          base;
        address = a; writeData = wd; memRead = rd; memWrite = wr;
        memSize = sz; memUnsigned = uns; faultClear = clr; rst = r;
        #2;
        expMis = (rd | wr) & refIsMis(a, sz);
        expRd  = (rd && !expMis) ? refLoad(a, sz, uns) : 32'd0;
        check("misaligned", {31'd0, misaligned}, {31'd0, expMis});
        check("readData", readData, expRd);
        obs = readData;
        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
            refFlag = 1'b0;
            refAddr = 32'd0;
        end else begin
            if (wr && !expMis) begin
                base = int'(a % 1024);
                for (int i = 0; i < (1 << sz); i++) refMem[base + i] = wd[8*i +: 8];
            end
            if (expMis && (!refFlag || clr)) begin
                refFlag = 1'b1;
                refAddr = a;
            end else if (clr) begin
                refFlag = 1'b0;
            end
        end
        check("faultFlag", {31'd0, faultFlag}, {31'd0, refFlag});
        check("faultAddr", faultAddr, refAddr);
    endtask

    logic [31:0] obs;
    logic [31:0] ra;

    initial begin
        for (int i = 0; i < 1024; i++) refMem[i] = 8'h00;
        refFlag = 1'b0;
        refAddr = 32'd0;

        // Reset, then the cleared array reads back as zero.
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, obs);
        cycle(32'h0,   32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("reset LW 0x0", obs, 32'h0);
        cycle(32'h3FC, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("reset LW 0x3FC", obs, 32'h0);
        check("reset faultFlag", {31'd0, faultFlag}, 32'd0);

        // Sign/zero extension of a stored word.
        cycle(32'h10, 32'h8000_00F1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h10, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, obs);
        check("LB 0x10", obs, 32'hFFFF_FFF1);
        cycle(32'h10, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, obs);
        check("LBU 0x10", obs, 32'h0000_00F1);
        cycle(32'h10, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, obs);
        check("LH 0x10", obs, 32'h0000_00F1);
        cycle(32'h10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, obs);
        check("LW 0x10", obs, 32'h8000_00F1);
        cycle(32'h13, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, obs);
        check("LB 0x13", obs, 32'hFFFF_FF80);

        // Byte and half stores touch only their lanes.
        cycle(32'h20, 32'h1122_3344, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h22, 32'hFFFF_FFAB, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("LW after SB", obs, 32'h11AB_3344);
        cycle(32'h20, 32'h1234_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("LW after SH", obs, 32'h11AB_BEEF);

        // Misaligned store is suppressed and captured; later faults held until clear.
        cycle(32'h21, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("SW 0x21 faultFlag", {31'd0, faultFlag}, 32'd1);
        check("SW 0x21 faultAddr", faultAddr, 32'h21);
        cycle(32'h20, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("LW after bad SW", obs, 32'h11AB_BEEF);
        cycle(32'h03, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, obs);
        check("LH 0x03 faultAddr", faultAddr, 32'h21);
        cycle(32'h05, 32'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, obs);
        check("clear+fault flag", {31'd0, faultFlag}, 32'd1);
        check("clear+fault addr", faultAddr, 32'h05);
        cycle(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, obs);
        check("clear alone", {31'd0, faultFlag}, 32'd0);

        // Wrap-around, read-during-write, store during reset.
        cycle(32'h400, 32'hCAFE_0001, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h0, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("wrap LW 0x0", obs, 32'hCAFE_0001);
        cycle(32'h8, 32'h1111_1111, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        cycle(32'h8, 32'h2222_2222, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("RDW old", obs, 32'h1111_1111);
        cycle(32'h8, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("RDW new", obs, 32'h2222_2222);
        cycle(32'h30, 32'h5555_5555, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, obs);
        cycle(32'h30, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, obs);
        check("SW during rst", obs, 32'h0);

        // Randomized traffic, with addresses mostly in range but sometimes wrapping.
        for (int n = 0; n < 2000; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 3) != 0) ra = ra & 32'h0000_00FF;
            cycle(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0), obs);
        end

        cycle(32'h0, 32'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, obs);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
